// File: rtl/frame_bus_arbiter_if.sv
// Wishbone classic bus bundle for the frame-buffer arbiter.
// master = the side that initiates cycles, slave = the side that answers them.
interface frame_bus_arbiter_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_BYTES    = 1
);
    logic [ADDRESS_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0]    dat_w;
    logic [DATA_WIDTH-1:0]    dat_r;
    logic                     we;
    logic [DATA_BYTES-1:0]    sel;
    logic                     stb;
    logic                     cyc;
    logic [2:0]               cti;
    logic                     ack;
    logic                     err;

    modport master (output adr, dat_w, we, sel, stb, cyc, cti, input dat_r, ack, err);
    modport slave  (input adr, dat_w, we, sel, stb, cyc, cti, output dat_r, ack, err);
endinterface

// File: rtl/frame_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter for the shared frame-buffer RAM port.
// Optional stall timeout is enabled by defining FRAME_BUS_ARB_TIMEOUT_EN.
module frame_bus_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_BYTES    = 1,
    parameter int MAX_WAIT      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    frame_bus_arbiter_if.slave    m0,
    frame_bus_arbiter_if.slave    m1,
    frame_bus_arbiter_if.master   s,
    output logic [1:0]            grant_o
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t                   r_state;
    logic                     r_last_owner;
    logic [1:0]               r_grant;
    logic                     w_own0;
    logic                     w_own1;
    logic                     w_timeout;
    logic [ADDRESS_WIDTH-1:0] w_adr;
    logic [DATA_WIDTH-1:0]    w_dat;
    logic                     w_we;
    logic [DATA_BYTES-1:0]    w_sel;
    logic                     w_stb;
    logic                     w_cyc;
    logic [2:0]               w_cti;

    assign w_own0 = (r_state == OWN0);
    assign w_own1 = (r_state == OWN1);

`ifdef FRAME_BUS_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] r_wait;
    logic              w_stall;

    assign w_stall   = ((w_own0 & m0.stb) | (w_own1 & m1.stb)) & ~s.ack;
    // Fires on the MAX_WAIT-th consecutive stalled cycle, not one after.
    assign w_timeout = w_stall & (r_wait == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || r_state == IDLE || s.ack) begin
            r_wait <= '0;
        end else if (w_stall) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end
`else
    // No timeout: the grant is held for as long as the owner keeps cyc high.
    assign w_timeout = (MAX_WAIT < 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_last_owner <= 1'b1;
            r_grant      <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0.cyc && (!m1.cyc || r_last_owner)) begin
                        r_state <= OWN0;
                        r_grant <= 2'b01;
                    end else if (m1.cyc) begin
                        r_state <= OWN1;
                        r_grant <= 2'b10;
                    end
                end
                OWN0: begin
                    if (!m0.cyc || w_timeout) begin
                        r_state      <= IDLE;
                        r_grant      <= 2'b00;
                        r_last_owner <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m1.cyc || w_timeout) begin
                        r_state      <= IDLE;
                        r_grant      <= 2'b00;
                        r_last_owner <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    assign grant_o = r_grant;

    always_comb begin
        w_adr = '0;
        w_dat = '0;
        w_we  = 1'b0;
        w_sel = '0;
        w_stb = 1'b0;
        w_cyc = 1'b0;
        w_cti = 3'b000;
        if (w_own0) begin
            w_adr = m0.adr;
            w_dat = m0.dat_w;
            w_we  = m0.we;
            w_sel = m0.sel;
            w_stb = m0.stb;
            w_cyc = m0.cyc;
            w_cti = m0.cti;
        end else if (w_own1) begin
            w_adr = m1.adr;
            w_dat = m1.dat_w;
            w_we  = m1.we;
            w_sel = m1.sel;
            w_stb = m1.stb;
            w_cyc = m1.cyc;
            w_cti = m1.cti;
        end
        if (w_timeout) begin
            w_cyc = 1'b0;
            w_stb = 1'b0;
        end
    end

    assign s.adr   = w_adr;
    assign s.dat_w = w_dat;
    assign s.we    = w_we;
    assign s.sel   = w_sel;
    assign s.stb   = w_stb;
    assign s.cyc   = w_cyc;
    assign s.cti   = w_cti;

    // Read data fans out to both; only the owner's ack qualifies it.
    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;
    assign m0.ack   = w_own0 & m0.cyc & s.ack & ~w_timeout;
    assign m1.ack   = w_own1 & m1.cyc & s.ack & ~w_timeout;
    assign m0.err   = w_own0 & w_timeout;
    assign m1.err   = w_own1 & w_timeout;
endmodule

// File: tb/tb_frame_bus_arbiter.sv
// Scoreboard bench for frame_bus_arbiter: directed traffic, ack monitor against an expected queue.
module tb_frame_bus_arbiter;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] grant_o;
  logic       slave_en = 1'b1;
  int         checks = 0;
  int         errors = 0;

  // expected ack entry: {ack_m1, ack_m0, we, cti, adr, data}
  logic [29:0] exp_q[$];
  logic [1:0]  grant_log[$];
  logic        log_en = 1'b0;
  logic [1:0]  prev_grant = 2'b00;

  frame_bus_arbiter_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8), .DATA_BYTES(1)) m0_bus ();
  frame_bus_arbiter_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8), .DATA_BYTES(1)) m1_bus ();
  frame_bus_arbiter_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8), .DATA_BYTES(1)) s_bus ();

  frame_bus_arbiter #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8), .DATA_BYTES(1), .MAX_WAIT(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .s       (s_bus),
    .grant_o (grant_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // slave RAM model: read data is a fixed function of address, single-cycle ack
  assign s_bus.dat_r = s_bus.adr[7:0] ^ 8'h10;
  assign s_bus.err   = 1'b0;
  initial s_bus.ack = 1'b0;
  always @(posedge clk_i) begin
    #2;
    s_bus.ack = slave_en && s_bus.cyc && s_bus.stb;
  end

  function automatic logic [29:0] exp_entry(int m, logic we, logic [2:0] cti,
                                            logic [15:0] adr, logic [7:0] wdat);
    logic [1:0] who;
    who = (m == 0) ? 2'b01 : 2'b10;
    return {who, we, cti, adr, (we ? wdat : (adr[7:0] ^ 8'h10))};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_m(int m, logic cyc, logic stb, logic we, logic [15:0] adr,
                       logic [7:0] dat, logic [2:0] cti);
    if (m == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we; m0_bus.adr = adr;
      m0_bus.dat_w = dat; m0_bus.cti = cti; m0_bus.sel = 1'b1;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we; m1_bus.adr = adr;
      m1_bus.dat_w = dat; m1_bus.cti = cti; m1_bus.sel = 1'b1;
    end
  endtask

  task automatic release_m(int m);
    set_m(m, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 3'b000);
  endtask

  task automatic wait_ack(int m);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk_i);
      n++;
      got = (m == 0) ? m0_bus.ack : m1_bus.ack;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout_m%0d: got no ack, required ack within 60 cycles", m);
    end
  endtask

  task automatic wait_grant(logic [1:0] g);
    int n;
    n = 0;
    while (grant_o !== g && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    if (grant_o !== g) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got %0h required %0h", grant_o, g);
    end
  endtask

  // one beat: drive, wait for owner ack, return at posedge+1 ready for next beat
  task automatic beat(int m, logic we, logic [15:0] adr, logic [7:0] dat,
                      logic [2:0] cti, logic push);
    if (push) exp_q.push_back(exp_entry(m, we, cti, adr, dat));
    set_m(m, 1'b1, 1'b1, we, adr, dat, cti);
    wait_ack(m);
    @(posedge clk_i);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk_i) begin
    logic [29:0] act;
    logic [29:0] e;
    if (m0_bus.ack || m1_bus.ack) begin
      act = {m1_bus.ack, m0_bus.ack, s_bus.we, s_bus.cti, s_bus.adr,
             (s_bus.we ? s_bus.dat_w : (m1_bus.ack ? m1_bus.dat_r : m0_bus.dat_r))};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got %h required no ack", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL ack_txn: got %h required %h", act, e);
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (log_en && grant_o != 2'b00 && grant_o != prev_grant) grant_log.push_back(grant_o);
    prev_grant = grant_o;
  end

  initial begin
    int stall;
    int bad;
    release_m(0);
    release_m(1);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // reset state
    @(negedge clk_i);
    check("rst_grant", grant_o, 2'b00);
    check("rst_s_cyc", s_bus.cyc, 1'b0);
    check("rst_err", {m1_bus.err, m0_bus.err}, 2'b00);

    // m0 single read of 0x0005, 1-cycle arbitration latency
    @(posedge clk_i); #1;
    exp_q.push_back(exp_entry(0, 1'b0, 3'b000, 16'h0005, 8'h00));
    set_m(0, 1'b1, 1'b1, 1'b0, 16'h0005, 8'h00, 3'b000);
    @(negedge clk_i);
    check("t1_s_cyc_latency", s_bus.cyc, 1'b0);
    @(negedge clk_i);
    check("t1_s_cyc", s_bus.cyc, 1'b1);
    check("t1_grant", grant_o, 2'b01);
    check("t1_ack_m0", m0_bus.ack, 1'b1);
    check("t1_dat_m0", m0_bus.dat_r, 8'h15);
    @(posedge clk_i); #1;
    release_m(0);
    repeat (2) @(posedge clk_i);

    // simultaneous request after reset: m0 first, one dead cycle, then m1 write
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    set_m(1, 1'b1, 1'b1, 1'b1, 16'h0100, 8'hA5, 3'b000);
    beat(0, 1'b0, 16'h0010, 8'h00, 3'b000, 1'b1);
    release_m(0);
    exp_q.push_back(exp_entry(1, 1'b1, 3'b000, 16'h0100, 8'hA5));
    @(negedge clk_i);
    check("t2_hold_grant", grant_o, 2'b01);
    @(negedge clk_i);
    check("t2_dead_grant", grant_o, 2'b00);
    check("t2_dead_cyc", s_bus.cyc, 1'b0);
    @(negedge clk_i);
    check("t2_m1_grant", grant_o, 2'b10);
    check("t2_m1_wdata", {s_bus.we, s_bus.adr, s_bus.dat_w}, {1'b1, 16'h0100, 8'hA5});
    @(posedge clk_i); #1;
    release_m(1);
    repeat (2) @(posedge clk_i);
    #1;

    // back-to-back contention, 4 rounds
    exp_q.push_back(exp_entry(0, 1'b0, 3'b000, 16'h0020, 8'h00));
    exp_q.push_back(exp_entry(1, 1'b0, 3'b000, 16'h0031, 8'h00));
    exp_q.push_back(exp_entry(0, 1'b0, 3'b000, 16'h0022, 8'h00));
    exp_q.push_back(exp_entry(1, 1'b0, 3'b000, 16'h0033, 8'h00));
    grant_log.delete();
    log_en = 1'b1;
    fork
      begin
        for (int r = 0; r < 2; r++) begin
          beat(0, 1'b0, 16'h0020 + 16'(2 * r), 8'h00, 3'b000, 1'b0);
          release_m(0);
          @(posedge clk_i); #1;
        end
      end
      begin
        for (int r = 0; r < 2; r++) begin
          beat(1, 1'b0, 16'h0031 + 16'(2 * r), 8'h00, 3'b000, 1'b0);
          release_m(1);
          @(posedge clk_i); #1;
        end
      end
    join
    repeat (3) @(negedge clk_i);
    log_en = 1'b0;
    check("t3_rounds", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("t3_order_%0d", i), grant_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);

    // 8-beat incrementing burst from m0 while m1 waits
    @(posedge clk_i); #1;
    for (int i = 0; i < 8; i++)
      exp_q.push_back(exp_entry(0, 1'b0, (i < 7) ? 3'b010 : 3'b111, 16'h0040 + 16'(i), 8'h00));
    exp_q.push_back(exp_entry(1, 1'b1, 3'b000, 16'h0200, 8'h3C));
    grant_log.delete();
    log_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          beat(0, 1'b0, 16'h0040 + 16'(i), 8'h00, (i < 7) ? 3'b010 : 3'b111, 1'b0);
        release_m(0);
      end
      begin
        repeat (2) @(posedge clk_i);
        #1;
        set_m(1, 1'b1, 1'b1, 1'b1, 16'h0200, 8'h3C, 3'b000);
        wait_ack(1);
        @(posedge clk_i); #1;
        release_m(1);
      end
    join
    repeat (3) @(negedge clk_i);
    log_en = 1'b0;
    check("t4_grant_seq_len", grant_log.size(), 2);
    if (grant_log.size() == 2) check("t4_grant_seq", {grant_log[0], grant_log[1]}, 4'b0110);

    // reset during m1 ownership with the slave stalled
    @(posedge clk_i); #1;
    slave_en = 1'b0;
    set_m(1, 1'b1, 1'b1, 1'b1, 16'h0300, 8'h77, 3'b000);
    wait_grant(2'b10);
    check("t5_s_cyc_before", s_bus.cyc, 1'b1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("t5_grant", grant_o, 2'b00);
    check("t5_s_cyc", s_bus.cyc, 1'b0);
    check("t5_s_adr", s_bus.adr, 16'h0000);
    check("t5_acks", {m1_bus.ack, m0_bus.ack}, 2'b00);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    release_m(1);
    slave_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

`ifdef FRAME_BUS_ARB_TIMEOUT_EN
    // m1 never acked: err on the 8th stall, then pending m0 is served
    slave_en = 1'b0;
    set_m(1, 1'b1, 1'b1, 1'b0, 16'h0400, 8'h00, 3'b000);
    @(posedge clk_i); #1;
    exp_q.push_back(exp_entry(0, 1'b0, 3'b000, 16'h0050, 8'h00));
    set_m(0, 1'b1, 1'b1, 1'b0, 16'h0050, 8'h00, 3'b000);
    stall = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk_i);
      if (grant_o == 2'b10 && m1_bus.stb && !s_bus.ack) stall++;
      if (m1_bus.err) break;
    end
    check("t6_err_m1", m1_bus.err, 1'b1);
    check("t6_stall_count", stall, 8);
    check("t6_s_cyc_forced", s_bus.cyc, 1'b0);
    check("t6_err_m0", m0_bus.err, 1'b0);
    @(posedge clk_i); #1;
    release_m(1);
    slave_en = 1'b1;
    @(negedge clk_i);
    check("t6_err_pulse", m1_bus.err, 1'b0);
    wait_ack(0);
    check("t6_m0_grant", grant_o, 2'b01);
    @(posedge clk_i); #1;
    release_m(0);
`else
    // no timeout: stalled grant is held with no error
    slave_en = 1'b0;
    set_m(1, 1'b1, 1'b1, 1'b0, 16'h0400, 8'h00, 3'b000);
    wait_grant(2'b10);
    bad = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk_i);
      if (grant_o != 2'b10 || m1_bus.err || !s_bus.cyc) bad++;
    end
    check("t6_hold_no_err", bad, 0);
    @(posedge clk_i); #1;
    release_m(1);
    slave_en = 1'b1;
`endif

    repeat (4) @(negedge clk_i);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_bus_arbiter.md
Name: frame_bus_arbiter

Overview:
Two-master Wishbone arbiter for the shared frame-buffer RAM port. Master 0 is the led_matrix refresh reader (frame_* master port). Master 1 is the CPU/bridge, which writes pixel data. The arbiter grants the single slave port to one master per bus cycle, holds the grant for a whole cycle including bursts, and routes the slave ack back only to the owner.

Parameters:
ADDRESS_WIDTH, 16, Wishbone address width
DATA_WIDTH, 8, Wishbone data width
DATA_BYTES, 1, select width (DATA_WIDTH/8)
MAX_WAIT, 8, stall cycles before timeout (used only with the optional feature)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
mN_adr_i (N=0,1)  in  ADDRESS_WIDTH  master N address
mN_dat_i  in  DATA_WIDTH  master N write data
mN_dat_o  out  DATA_WIDTH  read data to master N
mN_we_i  in  1  master N write enable
mN_sel_i  in  DATA_BYTES  master N byte select
mN_stb_i  in  1  master N strobe
mN_cyc_i  in  1  master N cycle request
mN_cti_i  in  3  master N cycle type
mN_ack_o  out  1  ack to master N
mN_err_o  out  1  error to master N
s_adr_o  out  ADDRESS_WIDTH  slave address
s_dat_o  out  DATA_WIDTH  slave write data
s_dat_i  in  DATA_WIDTH  slave read data
s_we_o  out  1  slave write enable
s_sel_o  out  DATA_BYTES  slave byte select
s_stb_o  out  1  slave strobe
s_cyc_o  out  1  slave cycle
s_cti_o  out  3  slave cycle type
s_ack_i  in  1  slave ack
grant_o  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 0 = idle

Behaviour:
- FSM states: IDLE, OWN0, OWN1, all registered. Reset forces IDLE, grant_o = 0, last_owner = 1 so m0 wins the first tie.
- IDLE:
  - m0_cyc_i only -> OWN0 next cycle.
  - m1_cyc_i only -> OWN1 next cycle.
  - Both asserted -> the master that is not last_owner wins (round-robin).
  - Arbitration latency is exactly 1 cycle from cyc assertion to s_cyc_o.
- OWNn:
  - Slave outputs are combinationally muxed from master n.
  - s_cyc_o = mn_cyc_i; s_stb_o = mn_stb_i.
  - mn_ack_o = s_ack_i; the other master's ack_o = 0.
  - Grant is held while mn_cyc_i = 1, regardless of stb gaps or cti.
  - mn_cyc_i low -> IDLE next cycle and last_owner <= n.
  - No preemption; a waiting request is served from IDLE, giving a 1-cycle dead bus between owners.
- IDLE outputs:
  - s_cyc_o, s_stb_o, s_we_o = 0; s_adr_o, s_dat_o, s_sel_o, s_cti_o = 0.
  - Both ack_o = 0, both err_o = 0.
- m0_dat_o and m1_dat_o both carry s_dat_i unconditionally; only the owner's ack qualifies it.
- Burst (cti 3'b010) passes through unchanged. The end-of-burst cycle (3'b111) does not release the grant; only cyc drop does.
- A master dropping cyc mid-transfer: that ack is discarded, release proceeds as normal.
- rst_i mid-cycle: next edge goes to IDLE, all outputs go to reset values, and any in-flight ack is dropped.
- A non-owner asserting stb or cyc has no effect on the slave and receives no ack.

Optional Feature:
- Macro: FRAME_BUS_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on grant and on each s_ack_i.
  - It increments each cycle the owner has stb = 1 and s_ack_i = 0.
  - When it reaches MAX_WAIT, the owner's err_o pulses for 1 cycle.
  - s_cyc_o and s_stb_o are forced 0 that cycle, and the FSM goes to IDLE with last_owner = owner.
  - The owner must drop cyc; if it re-asserts, it re-arbitrates.
- Not defined: no counter; both err_o tied 0; grants are held indefinitely.

Test Plan:
- Reset, then m0 single read of adr 16'h0005 with slave returning 8'h15 -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o with m0_dat_o = 8'h15; m1_ack_o stays 0; grant_o = 2'b01.
- m0 and m1 assert cyc on the same cycle after reset -> m0 granted first. After m0 drops cyc: 1 idle cycle, then grant_o = 2'b10, and m1's write of 8'hA5 to 16'h0100 reaches the slave.
- Back-to-back contention for 4 rounds -> grants alternate m0, m1, m0, m1; no master is served twice consecutively while the other waits.
- m0 incrementing burst of 8 beats (cti 010…111) while m1 requests -> m1 is held off until m0_cyc_i falls; all 8 acks go only to m0.
- rst_i asserted during m1 ownership with ack pending -> next cycle grant_o = 0, s_cyc_o = 0, no ack to either master.
- With FRAME_BUS_ARB_TIMEOUT_EN and MAX_WAIT = 8, slave never acks an m1 strobe -> m1_err_o pulses on the 8th stall cycle, s_cyc_o drops, and a pending m0 is granted afterwards.
